// File: rtl/urv_dm_arb_pkg.sv
// Shared encodings for the uRV data-memory arbiter.
// State and owner constants, plus the width of the optional wait-state counter.
package urv_dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic OWNER_P0 = 1'b0;
    localparam logic OWNER_P1 = 1'b1;

    localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/urv_dm_arb_timeout.sv
// Wait-state counter for the data-memory arbiter.
// It is only instantiated when URV_DM_ARB_TIMEOUT_EN is defined.
module urv_dm_arb_timeout
    import urv_dm_arb_pkg::*;
#(
    parameter int g_limit = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TMO_CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i)
            cnt <= '0;
        else if (en_i)
            cnt <= cnt + 1'b1;
    end

    // The counter starts at 0 in the first enabled cycle. It expires on the
    // g_limit-th enabled cycle.
    assign expired_o = en_i && (cnt == TMO_CNT_W'(g_limit - 1));

endmodule

// File: rtl/urv_dm_arbiter.sv
// Two-master arbiter for the uRV data-memory port (port 0 = exec stage, port 1 = debug/DMA).
// Define URV_DM_ARB_TIMEOUT_EN to abort a wait after g_timeout_cycles and flag pN_err_o.
module urv_dm_arbiter
    import urv_dm_arb_pkg::*;
#(
    parameter int g_round_robin    = 0,
    parameter int g_timeout_cycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        p0_req_i,
    input  logic        p0_we_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_data_i,
    input  logic [3:0]  p0_sel_i,
    output logic        p0_done_o,
    output logic [31:0] p0_data_o,
    output logic        p0_err_o,
    input  logic        p1_req_i,
    input  logic        p1_we_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_data_i,
    input  logic [3:0]  p1_sel_i,
    output logic        p1_done_o,
    output logic [31:0] p1_data_o,
    output logic        p1_err_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_data_s_o,
    output logic [3:0]  dm_data_select_o,
    output logic        dm_load_o,
    output logic        dm_store_o,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    input  logic        dm_store_done_i,
    output logic        arb_busy_o,
    output logic        arb_owner_o
);

    arb_state_t  state, state_nxt;
    logic        owner, win;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  sel_q;
    logic [31:0] p0_rdata_q, p1_rdata_q;
    logic        p0_err_q, p1_err_q;
    logic        mem_done, tmo_expired, finish;

    if (g_timeout_cycles < 1 || g_timeout_cycles > 65535) begin : g_bad_timeout
        $error("urv_dm_arbiter: g_timeout_cycles must be 1..65535");
    end

    // The owner register holds the last owner, so round-robin uses its inverse.
    always_comb begin
        win = p1_req_i ? OWNER_P1 : OWNER_P0;
        if (p0_req_i && p1_req_i)
            win = (g_round_robin != 0) ? ~owner : OWNER_P0;
    end

    assign mem_done = we_q ? dm_store_done_i : dm_load_done_i;
    assign finish   = (state == WAIT) && (mem_done || tmo_expired);

`ifdef URV_DM_ARB_TIMEOUT_EN
    urv_dm_arb_timeout #(
        .g_limit (g_timeout_cycles)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clear_i   (state == ISSUE),
        .en_i      (state == WAIT),
        .expired_o (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (p0_req_i || p1_req_i) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mem_done || tmo_expired) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            owner      <= OWNER_P1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            p0_err_q   <= 1'b0;
            p1_err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (p0_req_i || p1_req_i)) begin
                owner   <= win;
                we_q    <= win ? p1_we_i   : p0_we_i;
                addr_q  <= win ? p1_addr_i : p0_addr_i;
                wdata_q <= win ? p1_data_i : p0_data_i;
                sel_q   <= win ? p1_sel_i  : p0_sel_i;
            end
            // A timeout abort returns zero data with the error flag set.
            if (finish) begin
                if (owner == OWNER_P1) begin
                    p1_rdata_q <= mem_done ? dm_data_l_i : 32'h0;
                    p1_err_q   <= !mem_done;
                end else begin
                    p0_rdata_q <= mem_done ? dm_data_l_i : 32'h0;
                    p0_err_q   <= !mem_done;
                end
            end
        end
    end

    assign dm_load_o        = (state == ISSUE) && !we_q;
    assign dm_store_o       = (state == ISSUE) && we_q;
    assign dm_addr_o        = addr_q;
    assign dm_data_s_o      = wdata_q;
    assign dm_data_select_o = sel_q;

    assign p0_done_o   = (state == DONE) && (owner == OWNER_P0);
    assign p1_done_o   = (state == DONE) && (owner == OWNER_P1);
    assign p0_data_o   = p0_rdata_q;
    assign p1_data_o   = p1_rdata_q;
    assign p0_err_o    = p0_err_q;
    assign p1_err_o    = p1_err_q;
    assign arb_busy_o  = (state != IDLE);
    assign arb_owner_o = owner;

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Bench for urv_dm_arbiter: two instances (fixed-priority and round-robin) behind behavioural memories,
// checked against a transaction-level model of grant order, latency and returned data.
module tb_urv_dm_arbiter;

    typedef struct { int port; logic [31:0] data; logic err; int cyc; } comp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; logic [3:0] sel; logic own; int cyc; } strb_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; logic [3:0] sel; } txn_t;

    logic clk = 1'b0;
    logic rst_n;
    logic p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_data, p1_addr, p1_data;
    logic [3:0]  p0_sel, p1_sel;

    logic p0_done[2], p1_done[2], p0_err[2], p1_err[2];
    logic dm_load[2], dm_store[2], busy[2], owner[2];
    logic [31:0] p0_rd[2], p1_rd[2], dm_addr[2], dm_wd[2];
    logic [3:0]  dm_sel[2];
    logic ld_in[2], st_in[2];
    logic [31:0] rd_in[2];

    logic ld_m[2], st_m[2], auto_en[2];
    int   mem_lat = 3;
    logic lat_rand = 1'b0, use_fix = 1'b0;
    logic [31:0] fix_val = 32'h0;

    comp_t cq[2][$];
    strb_t sq[2][$];

    int errors = 0, checks = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic ld_a = 1'b0, st_a = 1'b0;
        logic [31:0] rd_a = 32'h0;
        int cnt = -1;
        logic wl;
        logic [31:0] al;

        assign ld_in[g] = ld_a | ld_m[g];
        assign st_in[g] = st_a | st_m[g];
        assign rd_in[g] = rd_a;

        urv_dm_arbiter #(
            .g_round_robin    (g),
            .g_timeout_cycles (8)
        ) dut (
            .clk_i            (clk),
            .rst_n_i          (rst_n),
            .p0_req_i         (p0_req),
            .p0_we_i          (p0_we),
            .p0_addr_i        (p0_addr),
            .p0_data_i        (p0_data),
            .p0_sel_i         (p0_sel),
            .p0_done_o        (p0_done[g]),
            .p0_data_o        (p0_rd[g]),
            .p0_err_o         (p0_err[g]),
            .p1_req_i         (p1_req),
            .p1_we_i          (p1_we),
            .p1_addr_i        (p1_addr),
            .p1_data_i        (p1_data),
            .p1_sel_i         (p1_sel),
            .p1_done_o        (p1_done[g]),
            .p1_data_o        (p1_rd[g]),
            .p1_err_o         (p1_err[g]),
            .dm_addr_o        (dm_addr[g]),
            .dm_data_s_o      (dm_wd[g]),
            .dm_data_select_o (dm_sel[g]),
            .dm_load_o        (dm_load[g]),
            .dm_store_o       (dm_store[g]),
            .dm_data_l_i      (rd_in[g]),
            .dm_load_done_i   (ld_in[g]),
            .dm_store_done_i  (st_in[g]),
            .arb_busy_o       (busy[g]),
            .arb_owner_o      (owner[g])
        );

        // Recorder plus auto-responding memory: done arrives 'lat' cycles after the strobe.
        always @(negedge clk) begin
            if (p0_done[g]) cq[g].push_back('{port: 0, data: p0_rd[g], err: p0_err[g], cyc: cyc});
            if (p1_done[g]) cq[g].push_back('{port: 1, data: p1_rd[g], err: p1_err[g], cyc: cyc});
            if (dm_load[g] || dm_store[g])
                sq[g].push_back('{we: dm_store[g], addr: dm_addr[g], data: dm_wd[g], sel: dm_sel[g], own: owner[g], cyc: cyc});
            ld_a = 1'b0; st_a = 1'b0; rd_a = $urandom;
            if (cnt == 1) begin
                if (wl) st_a = 1'b1;
                else begin ld_a = 1'b1; rd_a = use_fix ? fix_val : mem_f(al); end
                cnt = -1;
            end else if (cnt > 1) cnt--;
            if (auto_en[g] && (dm_load[g] || dm_store[g])) begin
                cnt = lat_rand ? int'($urandom_range(1, 4)) : mem_lat;
                wl = dm_store[g]; al = dm_addr[g];
            end
            if (!auto_en[g]) cnt = -1;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_data = 0; p0_sel = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_data = 0; p1_sel = 0;
        for (int g = 0; g < 2; g++) begin ld_m[g] = 0; st_m[g] = 0; auto_en[g] = 1; end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < 2; g++) begin cq[g].delete(); sq[g].delete(); end
    endtask

    // Hold a request until the chosen instance completes it, then drop it.
    task automatic drive(input int port, input int inst, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        int b = 0;
        logic seen = 1'b0;
        if (port == 0) begin p0_req = 1; p0_we = we; p0_addr = a; p0_data = d; p0_sel = s; end
        else           begin p1_req = 1; p1_we = we; p1_addr = a; p1_data = d; p1_sel = s; end
        while (!seen && b < 200) begin
            @(negedge clk); b++;
            seen = (port == 0) ? p0_done[inst] : p1_done[inst];
        end
        if (port == 0) p0_req = 0; else p1_req = 0;
        checks++;
        if (!seen) begin errors++; $display("FAIL drive_timeout: port %0d inst %0d no done after %0d cycles", port, inst, b); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({busy[g], owner[g], dm_load[g], dm_store[g], p0_done[g], p1_done[g], p0_err[g], p1_err[g]} !== 8'b0100_0000) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got busy=%b owner=%b ld=%b st=%b d0=%b d1=%b e0=%b e1=%b want 0 1 0 0 0 0 0 0", g,
                         busy[g], owner[g], dm_load[g], dm_store[g], p0_done[g], p1_done[g], p0_err[g], p1_err[g]);
            end
            checks++;
            if ({dm_addr[g], dm_wd[g], dm_sel[g], p0_rd[g], p1_rd[g]} !== '0) begin
                errors++;
                $display("FAIL reset_data[%0d]: addr=%h wd=%h sel=%h rd0=%h rd1=%h want all 0", g,
                         dm_addr[g], dm_wd[g], dm_sel[g], p0_rd[g], p1_rd[g]);
            end
        end
        do_reset();
    endtask

    task automatic test_single_load();
        int r;
        do_reset();
        lat_rand = 0; mem_lat = 3; use_fix = 1; fix_val = 32'hDEAD_BEEF;
        r = cyc;
        drive(0, 0, 1'b0, 32'h100, 32'h0, 4'hF);
        @(negedge clk); #1;
        checks++;
        if (sq[0].size() != 1 || cq[0].size() != 1) begin
            errors++; $display("FAIL single_counts: strobes=%0d comps=%0d want 1 1", sq[0].size(), cq[0].size());
        end else begin
            checks++;
            if (sq[0][0].we !== 1'b0 || sq[0][0].addr !== 32'h100 || sq[0][0].cyc != r + 1) begin
                errors++; $display("FAIL single_strobe: we=%b addr=%h cyc=%0d want 0 100 %0d", sq[0][0].we, sq[0][0].addr, sq[0][0].cyc, r + 1);
            end
            checks++;
            if (cq[0][0].port != 0 || cq[0][0].data !== 32'hDEAD_BEEF || cq[0][0].err !== 1'b0 || cq[0][0].cyc != r + 5) begin
                errors++; $display("FAIL single_done: port=%0d data=%h err=%b cyc=%0d want 0 deadbeef 0 %0d",
                                   cq[0][0].port, cq[0][0].data, cq[0][0].err, cq[0][0].cyc, r + 5);
            end
        end
        use_fix = 0;
    endtask

    task automatic test_tie_fixed();
        do_reset();
        lat_rand = 0; mem_lat = 2;
        fork
            drive(0, 0, 1'b1, 32'h200, 32'h1122_3344, 4'hF);
            drive(1, 0, 1'b0, 32'h300, 32'h0, 4'hF);
        join
        @(negedge clk); #1;
        checks++;
        if (sq[0].size() != 2 || cq[0].size() != 2) begin
            errors++; $display("FAIL tie_counts: strobes=%0d comps=%0d want 2 2", sq[0].size(), cq[0].size());
        end else begin
            checks++;
            if (sq[0][0].we !== 1'b1 || sq[0][0].addr !== 32'h200 || sq[0][0].data !== 32'h1122_3344 ||
                sq[0][0].sel !== 4'hF || sq[0][0].own !== 1'b0) begin
                errors++; $display("FAIL tie_first: we=%b addr=%h data=%h sel=%h own=%b want 1 200 11223344 f 0",
                                   sq[0][0].we, sq[0][0].addr, sq[0][0].data, sq[0][0].sel, sq[0][0].own);
            end
            checks++;
            if (sq[0][1].we !== 1'b0 || sq[0][1].addr !== 32'h300 || sq[0][1].own !== 1'b1) begin
                errors++; $display("FAIL tie_second: we=%b addr=%h own=%b want 0 300 1", sq[0][1].we, sq[0][1].addr, sq[0][1].own);
            end
            checks++;
            if (cq[0][0].port != 0 || cq[0][1].port != 1 || cq[0][1].data !== mem_f(32'h300)) begin
                errors++; $display("FAIL tie_done: ports=%0d,%0d data=%h want 0,1 %h", cq[0][0].port, cq[0][1].port,
                                   cq[0][1].data, mem_f(32'h300));
            end
            checks++;
            if (sq[0][1].cyc != cq[0][0].cyc + 2) begin
                errors++; $display("FAIL tie_regrant: second strobe cyc=%0d want %0d", sq[0][1].cyc, cq[0][0].cyc + 2);
            end
        end
    endtask

    // Both ports request back to back; the model replays the arbitration rule at transaction level.
    task automatic test_arb(input int g, input int n0, input int n1);
        txn_t t0[$], t1[$];
        int ord[$];
        int r0 = n0, r1 = n1, last = 1, i0 = 0, i1 = 0;
        do_reset();
        lat_rand = 1;
        for (int k = 0; k < n0 + n1; k++) begin
            txn_t t;
            t.we = $urandom_range(0, 1); t.addr = $urandom & 32'hFFFF_FFFC; t.data = $urandom; t.sel = $urandom_range(1, 15);
            if (k < n0) t0.push_back(t); else t1.push_back(t);
        end
        while (r0 + r1 > 0) begin
            int w;
            if (r0 > 0 && r1 > 0) w = (g != 0) ? 1 - last : 0;
            else w = (r0 > 0) ? 0 : 1;
            ord.push_back(w); last = w;
            if (w == 0) r0--; else r1--;
        end
        fork
            begin foreach (t0[k]) drive(0, g, t0[k].we, t0[k].addr, t0[k].data, t0[k].sel); end
            begin foreach (t1[k]) drive(1, g, t1[k].we, t1[k].addr, t1[k].data, t1[k].sel); end
        join
        @(negedge clk); #1;
        lat_rand = 0;
        checks++;
        if (sq[g].size() != n0 + n1 || cq[g].size() != n0 + n1) begin
            errors++; $display("FAIL arb%0d_counts: strobes=%0d comps=%0d want %0d", g, sq[g].size(), cq[g].size(), n0 + n1);
            return;
        end
        for (int k = 0; k < n0 + n1; k++) begin
            txn_t e;
            if (ord[k] == 0) begin e = t0[i0]; i0++; end else begin e = t1[i1]; i1++; end
            checks++;
            if (sq[g][k].own !== 1'(ord[k]) || cq[g][k].port != ord[k]) begin
                errors++; $display("FAIL arb%0d_order[%0d]: strobe owner=%b done port=%0d want %0d", g, k, sq[g][k].own, cq[g][k].port, ord[k]);
            end
            checks++;
            if (sq[g][k].we !== e.we || sq[g][k].addr !== e.addr || sq[g][k].data !== e.data || sq[g][k].sel !== e.sel) begin
                errors++; $display("FAIL arb%0d_fields[%0d]: we=%b addr=%h data=%h sel=%h want %b %h %h %h", g, k,
                                   sq[g][k].we, sq[g][k].addr, sq[g][k].data, sq[g][k].sel, e.we, e.addr, e.data, e.sel);
            end
            checks++;
            if (cq[g][k].err !== 1'b0 || (!e.we && cq[g][k].data !== mem_f(e.addr))) begin
                errors++; $display("FAIL arb%0d_data[%0d]: data=%h err=%b want %h 0", g, k, cq[g][k].data, cq[g][k].err, mem_f(e.addr));
            end
        end
    endtask

    task automatic test_done_during_issue();
        do_reset();
        auto_en[0] = 0; auto_en[1] = 0;
        fork
            drive(0, 0, 1'b1, 32'h40, 32'hCAFE_F00D, 4'b0100);
            begin
                int b = 0;
                while (!dm_store[0] && b < 20) begin @(negedge clk); b++; end
                st_m[0] = 1;                    // during ISSUE: must be ignored
                @(negedge clk); st_m[0] = 0; ld_m[0] = 1;  // wrong kind: ignored
                @(negedge clk); ld_m[0] = 0; st_m[0] = 1;
                @(negedge clk); st_m[0] = 0;
            end
        join
        @(negedge clk); #1;
        checks++;
        if (sq[0].size() != 1 || cq[0].size() != 1) begin
            errors++; $display("FAIL issue_counts: strobes=%0d comps=%0d want 1 1", sq[0].size(), cq[0].size());
        end else begin
            checks++;
            if (sq[0][0].sel !== 4'b0100 || sq[0][0].addr !== 32'h40 || sq[0][0].data !== 32'hCAFE_F00D || sq[0][0].we !== 1'b1) begin
                errors++; $display("FAIL issue_strobe: sel=%b addr=%h data=%h we=%b want 0100 40 cafef00d 1",
                                   sq[0][0].sel, sq[0][0].addr, sq[0][0].data, sq[0][0].we);
            end
            checks++;
            if (cq[0][0].port != 0 || cq[0][0].cyc != sq[0][0].cyc + 3) begin
                errors++; $display("FAIL issue_done: port=%0d cyc=%0d want 0 %0d", cq[0][0].port, cq[0][0].cyc, sq[0][0].cyc + 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b = 0;
        do_reset();
        lat_rand = 0; mem_lat = 1;
        drive(0, 0, 1'b0, 32'h84, 32'h0, 4'hF);
        auto_en[0] = 0; auto_en[1] = 0;
        p0_req = 1; p0_we = 0; p0_addr = 32'h88;
        while (!dm_load[0] && b < 20) begin @(negedge clk); b++; end
        @(negedge clk);
        rst_n = 0; p0_req = 0;
        repeat (2) @(negedge clk);
        rst_n = 1; ld_m[0] = 1; ld_m[1] = 1;
        @(negedge clk); ld_m[0] = 0; ld_m[1] = 0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (cq[0].size() != 1 || busy[0] !== 1'b0 || owner[0] !== 1'b1 || p0_rd[0] !== 32'h0) begin
            errors++; $display("FAIL rstmid_state: comps=%0d busy=%b owner=%b rd0=%h want 1 0 1 0", cq[0].size(), busy[0], owner[0], p0_rd[0]);
        end
        auto_en[0] = 1; auto_en[1] = 1;
        drive(0, 0, 1'b0, 32'h8C, 32'h0, 4'hF);
        #1;
        checks++;
        if (cq[0].size() != 2 || cq[0][cq[0].size()-1].data !== mem_f(32'h8C)) begin
            errors++; $display("FAIL rstmid_next: comps=%0d data=%h want 2 %h", cq[0].size(), cq[0][cq[0].size()-1].data, mem_f(32'h8C));
        end
    endtask

    task automatic test_timeout();
        do_reset();
        auto_en[0] = 0; auto_en[1] = 0;
`ifdef URV_DM_ARB_TIMEOUT_EN
        drive(1, 0, 1'b0, 32'h500, 32'h0, 4'hF);
        #1;
        checks++;
        if (cq[0].size() != 1 || sq[0].size() != 1) begin
            errors++; $display("FAIL timeout_counts: comps=%0d strobes=%0d want 1 1", cq[0].size(), sq[0].size());
        end else begin
            checks++;
            if (cq[0][0].port != 1 || cq[0][0].err !== 1'b1 || cq[0][0].data !== 32'h0 || cq[0][0].cyc != sq[0][0].cyc + 9) begin
                errors++; $display("FAIL timeout_abort: port=%0d err=%b data=%h cyc=%0d want 1 1 0 %0d",
                                   cq[0][0].port, cq[0][0].err, cq[0][0].data, cq[0][0].cyc, sq[0][0].cyc + 9);
            end
        end
`else
        p1_req = 1; p1_we = 0; p1_addr = 32'h500;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (busy[0] !== 1'b1 || cq[0].size() != 0 || p1_err[0] !== 1'b0) begin
            errors++; $display("FAIL no_timeout: busy=%b comps=%0d err=%b want 1 0 0", busy[0], cq[0].size(), p1_err[0]);
        end
        p1_req = 0;
`endif
        do_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < 2; g++) begin ld_m[g] = 0; st_m[g] = 0; auto_en[g] = 1; end
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_data = 0; p0_sel = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_data = 0; p1_sel = 0;
        test_reset();
        test_single_load();
        test_tie_fixed();
        test_arb(1, 2, 2);
        test_arb(0, 2, 2);
        for (int i = 0; i < 6; i++) test_arb(i % 2, $urandom_range(1, 3), $urandom_range(1, 3));
        test_done_during_issue();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
